// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 Wishbone read path.
package gfx256_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } rd_state_e;

  localparam int          LINE_BYTES = 32;
  localparam logic [31:0] SEL_ALL    = 32'hFFFF_FFFF;
endpackage

// File: rtl/gfx256_line_buf.sv
// Single-entry 256-bit line cache. A flush seen while a bus read is in
// flight poisons that read so stale data never lands in the buffer.
module gfx256_line_buf #(
  parameter int AW = 27
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_flush,
  input  logic          i_in_bus,
  input  logic          i_start,
  input  logic          i_load,
  input  logic [AW-1:0] i_lookup_adr,
  input  logic [AW-1:0] i_tag,
  input  logic [255:0]  i_data,
  output logic          o_hit,
  output logic [255:0]  o_data
);
  logic          r_valid;
  logic          r_flush_pend;
  logic [AW-1:0] r_tag;
  logic [255:0]  r_data;
  logic          w_do_load;

  assign w_do_load = i_load & ~r_flush_pend & ~i_flush;
  assign o_hit     = r_valid && (r_tag == i_lookup_adr);
  assign o_data    = r_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_flush_pend <= 1'b0;
      r_tag        <= '0;
      r_data       <= '0;
    end else begin
      if (i_start)
        r_flush_pend <= 1'b0;
      else if (i_flush && i_in_bus)
        r_flush_pend <= 1'b1;

      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_do_load) begin
        r_valid <= 1'b1;
        r_tag   <= i_tag;
        r_data  <= i_data;
      end
    end
  end
endmodule

// File: rtl/gfx256_wbm_read.sv
// Two-port round-robin Wishbone line-read master (z-buffer / texture)
// with a shared one-line buffer for back-to-back reads of the same line.
module gfx256_wbm_read
  import gfx256_pkg::*;
#(
  parameter int ADDR_HI     = 31,
  parameter bit LINE_BUF_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic [ADDR_HI:5] adr0_i,
  output logic             ack0_o,
  input  logic             req1_i,
  input  logic [ADDR_HI:5] adr1_i,
  output logic             ack1_o,
  output logic [255:0]     dat_o,
  output logic             busy_o,
  input  logic             flush_i,
  output logic             err_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [31:0]      m_sel_o,
  output logic [ADDR_HI:5] m_adr_o,
  input  logic [255:0]     m_dat_i,
  input  logic             m_ack_i,
  input  logic             m_err_i
);
  localparam int AW = ADDR_HI - 4;

  rd_state_e        r_state;
  logic             r_gnt;
  logic             r_last;
  logic             r_ack0, r_ack1;
  logic [255:0]     r_dat;
  logic             r_busy;
  logic             r_err;
  logic             r_cyc;
  logic [AW-1:0]    r_adr;

  logic             w_take;
  logic             w_sel;
  logic [AW-1:0]    w_adr;
  logic             w_buf_hit;
  logic [255:0]     w_buf_data;
  logic             w_hit;
  logic             w_start;
  logic             w_load;

  // While an ack is on the wire the requester still holds req; skip that
  // cycle so the same request is not granted twice.
  assign w_take  = (r_state == IDLE) & ~r_ack0 & ~r_ack1 & (req0_i | req1_i);
  assign w_sel   = (req0_i & req1_i) ? ~r_last : req1_i;
  assign w_adr   = w_sel ? adr1_i : adr0_i;
  assign w_hit   = LINE_BUF_EN && w_buf_hit && !flush_i;
  assign w_start = w_take & ~w_hit;
  assign w_load  = LINE_BUF_EN && (r_state == BUS) && m_ack_i && !m_err_i;

  gfx256_line_buf #(.AW(AW)) u_line_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_flush      (flush_i),
    .i_in_bus     (r_state == BUS),
    .i_start      (w_start),
    .i_load       (w_load),
    .i_lookup_adr (w_adr),
    .i_tag        (r_adr),
    .i_data       (m_dat_i),
    .o_hit        (w_buf_hit),
    .o_data       (w_buf_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_dat   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
      r_adr   <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_gnt  <= w_sel;
            r_last <= w_sel;
            r_busy <= 1'b1;
            if (w_hit) begin
              r_dat   <= w_buf_data;
              r_state <= RESP;
            end else begin
              r_adr   <= w_adr;
              r_cyc   <= 1'b1;
              r_state <= BUS;
            end
          end
        end
        BUS: begin
          // Error takes precedence over a coincident ack.
          if (m_err_i) begin
            r_dat   <= '0;
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_state <= RESP;
          end else if (m_ack_i) begin
            r_dat   <= m_dat_i;
            r_cyc   <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_ack0  <= ~r_gnt;
          r_ack1  <= r_gnt;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0_o  = r_ack0;
  assign ack1_o  = r_ack1;
  assign dat_o   = r_dat;
  assign busy_o  = r_busy;
  assign err_o   = r_err;
  assign m_cyc_o = r_cyc;
  assign m_stb_o = r_cyc;
  assign m_we_o  = 1'b0;
  assign m_sel_o = SEL_ALL;
  assign m_adr_o = r_adr;
endmodule

// File: doc/gfx256_wbm_read.md
Name: gfx256_wbm_read

Overview:
- Wishbone read master that services the 256-bit line read requests made by pixel-pipeline clients.
- Port 0 serves the z-buffer requester in the clip stage (z_request/z_addr/z_ack/z_data/wbm_busy). Port 1 serves the texture fetcher in the fragment stage.
- Round-robin arbitration between the two ports; one shared 256-bit line buffer lets repeated reads of the same line return without a bus cycle.
- Sits between the pipeline stages and the system Wishbone interconnect.

Parameters:
- ADDR_HI, 31, top bit of the line address; lines are 32 bytes, so addresses are [ADDR_HI:5].
- LINE_BUF_EN, 1, 1 enables the shared line buffer; 0 sends every request to the bus.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req0_i  in  1  port 0 (z-buffer) request, held until ack0_o
- adr0_i  in  [ADDR_HI:5]  port 0 line address, stable while req0_i is high
- ack0_o  out  1  port 0 one-cycle completion pulse
- req1_i  in  1  port 1 (texture) request
- adr1_i  in  [ADDR_HI:5]  port 1 line address
- ack1_o  out  1  port 1 completion pulse
- dat_o  out  256  returned line, shared by both ports
- busy_o  out  1  block not idle; drives the requester's wbm_busy input
- flush_i  in  1  invalidate the line buffer (pulsed by the writer after any memory write)
- err_o  out  1  sticky bus-error flag, cleared by rst_i
- m_cyc_o  out  1  Wishbone cycle
- m_stb_o  out  1  Wishbone strobe
- m_we_o  out  1  constant 0
- m_sel_o  out  32  constant 32'hFFFFFFFF
- m_adr_o  out  [ADDR_HI:5]  bus line address
- m_dat_i  in  256  bus read data
- m_ack_i  in  1  bus acknowledge
- m_err_i  in  1  bus error

Behaviour:
- Clock is clk_i. One clock domain. Reset is synchronous and active-high on rst_i.
- Reset values:
  - ack0_o/ack1_o/m_cyc_o/m_stb_o/busy_o/err_o = 0.
  - dat_o = 0, m_adr_o = 0.
  - Line buffer invalid; round-robin pointer = port 0.
- Reset mid-operation: cyc/stb drop in the same edge, the in-flight bus data is discarded, and no ack is issued.
- States (typedef rd_state_e): IDLE, BUS, RESP.
- IDLE:
  - Grant selection:
    - Only one request: grant that port.
    - Both requesting: grant the port other than the last one granted.
    - The pointer updates on grant.
  - Hit: line buffer valid, granted address == tag, LINE_BUF_EN=1, and flush_i low. Then dat_o <= buffer and the next state is RESP. No bus cycle occurs; ack follows 2 cycles after req.
  - Miss: latch m_adr_o, assert cyc/stb on the next edge, go to BUS.
  - busy_o = 0 only in IDLE with no grant being taken.
- BUS:
  - cyc/stb stay high until m_ack_i or m_err_i.
  - On m_ack_i: dat_o <= m_dat_i; the line buffer loads tag and data unless a flush arrived during BUS; deassert cyc/stb; go to RESP.
  - On m_err_i: dat_o <= 0, err_o <= 1, buffer unchanged; go to RESP.
  - If m_ack_i and m_err_i are high in the same cycle, err wins.
- RESP:
  - Pulse ack for the granted port for exactly 1 cycle, then return to IDLE.
  - Requests are not sampled in RESP. This gives the requester the cycle it needs to drop req after ack.
- dat_o holds stable from the ack pulse until the next grant.
- Flush:
  - flush_i in any state clears valid on the next edge.
  - A flush during BUS sets flush_pend. The returning data is then still delivered to the requester but not cached.
  - flush_i high in the same cycle as an IDLE lookup forces a miss.
- busy_o = (state != IDLE) | grant_taken. It is registered and rises the cycle after the grant edge; the requester tolerates this one-cycle lag because it holds req until ack.
- No timeout. A bus that never acks hangs in BUS; the bench covers only the legal bus.

Decomposition:
- gfx256_pkg gains:
  - rd_state_e
  - constant LINE_BYTES = 32
  - constant SEL_ALL = 32'hFFFFFFFF
- Sub-module gfx256_line_buf (tag/valid/data register plus flush_pend, outputs hit). It is instantiated once and bypassed when LINE_BUF_EN=0.

Test Plan:
- Port 0 miss: req0, adr0=27'h0000123, bus acks after 3 waits with data D1 → m_adr_o=27'h123, cyc high for 4 cycles, ack0 single pulse with dat_o=D1, busy_o high throughout.
- Port 0 hit: repeat adr0=27'h123 → no cyc, ack0 2 cycles after req with dat_o=D1.
- Simultaneous: req0 (adr 27'h10) and req1 (adr 27'h20) in the same cycle, last grant port 0 → port 1 serviced first, then port 0; exactly one ack each, in that order.
- Flush during BUS: flush_i pulses while cyc is high for 27'h30 → ack carries bus data; the next read of 27'h30 issues a new bus cycle.
- Bus error: m_err_i on a read of 27'h40 → ack with dat_o=0, err_o stays 1 until reset; a later read of 27'h40 still goes to the bus.
- Reset mid-BUS: rst_i with cyc high → cyc/stb low at the next edge, no ack, line buffer invalid, and the first post-reset read goes to the bus.
